dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//   Data-side memory for the RV32I single-cycle core. Consumes the core's
//   MemWrite / ALUResult (address) / WriteData outputs and returns ReadData
//   combinationally in the same cycle. Decodes a small word RAM plus an MMIO
//   window: GPIO register, free-running cycle counter, and a byte TX FIFO
//   drained over a valid/ready debug port.
// PARAMETERS
//   DMEM_WORDS  64            RAM depth in 32-bit words (power of 2)
//   MMIO_BASE   32'h0000_1000 Base address of the MMIO window (16-byte aligned)
//   FIFO_DEPTH  4             TX FIFO entries (power of 2, >=2)
// PORTS
//   clk        in   1   Core clock; all state updates on the rising edge
//   reset      in   1   Synchronous, active-high reset
//   MemWrite   in   1   Store strobe from the core
//   ALUResult  in   32  Byte address from the core
//   WriteData  in   32  Store data from the core
//   ReadData   out  32  Load data to the core (combinational)
//   gpio_out   out  32  GPIO register value
//   dbg_valid  out  1   TX FIFO not empty
//   dbg_data   out  8   TX FIFO head byte
//   dbg_ready  in   1   Sink accepts the head byte this cycle
// BEHAVIOUR
// - Address decode ignores ALUResult[1:0] (word access only):
//   RAM hit: ALUResult < DMEM_WORDS*4; index = ALUResult[log2(DMEM_WORDS)+1:2].
//   MMIO: MMIO_BASE+0x0 GPIO (RW), +0x4 CYCLE (RO), +0x8 TXDATA (WO),
//   +0xC STATUS (RW1C bit 2). All other addresses: read 0, write ignored.
// - RAM: write on the clock edge when MemWrite and RAM hit. Read is
//   combinational. Contents are not reset.
//   Same-cycle write then read of one word: read returns the old value;
//   the new value is visible from the next cycle.
// - GPIO: reset 0. On a write, loads WriteData at the edge.
// - CYCLE: reset 0. Increments by 1 every cycle, including the cycle after
//   reset deasserts. Wraps 32'hFFFF_FFFF -> 0. Writes are ignored.
// - TXDATA: a write pushes WriteData[7:0]. Reads return 0.
//   Push when full without a same-cycle pop: byte dropped, overflow flag set.
// - STATUS read: [0] full, [1] empty, [2] overflow (sticky),
//   [15:8] occupancy count, all other bits 0.
//   Writing STATUS with WriteData[2]=1 clears overflow.
//   Set and clear in the same cycle is impossible (different addresses).
// - FIFO: circular buffer with wr_ptr, rd_ptr and count.
//   dbg_valid = (count != 0). dbg_data = mem[rd_ptr], held stable while
//   dbg_valid && !dbg_ready.
//   Pop on an edge where dbg_valid && dbg_ready.
//   Simultaneous push and pop: both happen, count unchanged. This is legal
//   when full; the push is accepted and overflow is not set.
//   Push into empty: dbg_valid rises the next cycle (no fall-through).
//   Pointers wrap modulo FIFO_DEPTH.
// - Reset (any time, including mid-drain): gpio_out=0, CYCLE=0,
//   count=0, pointers=0, overflow=0, dbg_valid=0. RAM is untouched.
//   ReadData follows the decode at all times and has no reset value.
// - Latency: loads 0 cycles, stores 1 edge, FIFO push -> dbg_valid 1 cycle.
// TESTING
// 1 RAM: write 0xDEADBEEF @0x10; read @0x10 next cycle -> 0xDEADBEEF.
//   Read @0x13 -> same word. Read @0x400 (unmapped) -> 0.
// 2 GPIO/CYCLE: reset 3 cycles, release; read CYCLE 5 cycles later -> 5.
//   Write GPIO 0xA5A5_0001 -> gpio_out=0xA5A50001 next cycle.
//   Force CYCLE to 0xFFFFFFFF -> wraps to 0.
// 3 FIFO fill: dbg_ready=0; push 0x11,0x22,0x33,0x44 -> STATUS=0x0401.
//   Push 0x55 -> dropped, STATUS=0x0405.
//   Write STATUS 0x4 -> STATUS=0x0401.
// 4 Drain: dbg_ready=1 -> dbg_data 0x11,0x22,0x33,0x44 on consecutive
//   cycles, then dbg_valid=0 and STATUS=0x0002.
// 5 Full + simultaneous: FIFO full, dbg_ready=1, push 0x66 in the same
//   cycle -> count stays 4, overflow=0, 0x66 emerges last.
// 6 Reset mid-drain: 3 entries queued, assert reset one cycle ->
//   dbg_valid=0, STATUS=0x0002, gpio_out=0, RAM word from test 1 intact.

Source files
------------

// File: rtl/dmem_mmio.sv
// dmem_mmio - data-side memory for the RV32I single-cycle core.
//
// Word RAM with combinational read and clocked write, plus a 16-byte MMIO
// window holding a GPIO register, a free-running cycle counter and a byte
// TX FIFO that drains over a valid/ready debug port.
//
// Ports
//   clk        core clock, all state changes on the rising edge
//   reset      synchronous, active-high reset (RAM contents are kept)
//   MemWrite   store strobe from the core
//   ALUResult  byte address (bits [1:0] ignored, word access only)
//   WriteData  store data
//   ReadData   load data, combinational from the current address
//   gpio_out   GPIO register
//   dbg_valid  TX FIFO holds at least one byte
//   dbg_data   TX FIFO head byte
//   dbg_ready  sink takes the head byte on this edge
module dmem_mmio #(
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        dbg_valid,
    output logic [7:0]  dbg_data,
    input  logic        dbg_ready
);

    localparam int RAM_AW = $clog2(DMEM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [31:0]      RAM_BYTES = 32'(DMEM_WORDS * 4);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    localparam logic [1:0] REG_GPIO   = 2'd0;
    localparam logic [1:0] REG_CYCLE  = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Storage
    logic [31:0]      ram_r      [DMEM_WORDS];
    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [31:0]      cycle_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    // Decode and control
    logic              ram_hit_s;
    logic              mmio_hit_s;
    logic [1:0]        reg_sel_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              gpio_we_s;
    logic              tx_push_s;
    logic              status_clr_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_pop_s;
    logic              push_accept_s;
    logic              overflow_set_s;
    logic [31:0]       status_word_s;

    // Byte-offset bits never take part in decode.
    logic unused_s;
    assign unused_s = &{1'b0, ALUResult[1:0]};

    // Address decode; RAM takes priority should the windows ever overlap.
    always_comb begin
        ram_hit_s  = (ALUResult < RAM_BYTES);
        mmio_hit_s = 1'b0;
        if (!ram_hit_s) begin
            mmio_hit_s = (ALUResult[31:4] == MMIO_BASE[31:4]);
        end else begin
            mmio_hit_s = 1'b0;
        end
        reg_sel_s = ALUResult[3:2];
        ram_idx_s = ALUResult[RAM_AW+1:2];
    end

    // Store strobes and FIFO handshake qualification.
    always_comb begin
        gpio_we_s    = MemWrite && mmio_hit_s && (reg_sel_s == REG_GPIO);
        tx_push_s    = MemWrite && mmio_hit_s && (reg_sel_s == REG_TXDATA);
        status_clr_s = MemWrite && mmio_hit_s && (reg_sel_s == REG_STATUS) && WriteData[2];
        fifo_full_s  = (count_r == CNT_FULL);
        fifo_empty_s = (count_r == CNT_ZERO);
        fifo_pop_s   = !fifo_empty_s && dbg_ready;
        // A pop on the same edge frees a slot, so a push into a full FIFO
        // still lands and is not an overflow.
        push_accept_s  = tx_push_s && (!fifo_full_s || fifo_pop_s);
        overflow_set_s = tx_push_s && fifo_full_s && !fifo_pop_s;
        status_word_s  = {16'h0000, 8'(count_r), 5'b00000,
                          overflow_r, fifo_empty_s, fifo_full_s};
    end

    // Load data mux; anything unmapped or write-only reads as zero.
    always_comb begin
        ReadData = 32'h0000_0000;
        if (ram_hit_s) begin
            ReadData = ram_r[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (reg_sel_s)
                REG_GPIO:   ReadData = gpio_out;
                REG_CYCLE:  ReadData = cycle_r;
                REG_TXDATA: ReadData = 32'h0000_0000;
                REG_STATUS: ReadData = status_word_s;
                default:    ReadData = 32'h0000_0000;
            endcase
        end else begin
            ReadData = 32'h0000_0000;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit_s) begin
            ram_r[ram_idx_s] <= WriteData;
        end
    end

    // GPIO, cycle counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out   <= 32'h0000_0000;
            cycle_r    <= 32'h0000_0000;
            overflow_r <= 1'b0;
        end else begin
            if (gpio_we_s) begin
                gpio_out <= WriteData;
            end
            cycle_r <= cycle_r + 32'd1;
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (status_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO byte storage; only pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push_accept_s) begin
            fifo_mem_r[wr_ptr_r] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_accept_s, fifo_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dbg_valid = !fifo_empty_s;
    assign dbg_data  = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    localparam logic [31:0] A_GPIO = 32'h0000_1000;
    localparam logic [31:0] A_CYC  = 32'h0000_1004;
    localparam logic [31:0] A_TX   = 32'h0000_1008;
    localparam logic [31:0] A_ST   = 32'h0000_100C;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic        dbg_valid;
    logic [7:0]  dbg_data;
    logic        dbg_ready;

    always #5 clk = ~clk;

    dmem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .gpio_out  (gpio_out),
        .dbg_valid (dbg_valid),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain arrays, a byte queue and counters.
    logic [31:0] ram_m   [64];
    bit          ram_known [64];
    logic [31:0] gpio_m  = 32'h0;
    logic [31:0] cycle_m = 32'h0;
    bit          ovf_m   = 1'b0;
    logic [7:0]  q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >= 32'h100) && (a[31:4] == A_GPIO[31:4]);
    endfunction

    // What a load from address a should return, from the model state.
    task automatic model_rd(input logic [31:0] a, output logic [31:0] e, output bit known);
        int n;
        n     = q.size();
        known = 1'b1;
        e     = 32'h0;
        if (a < 32'h100) begin
            known = ram_known[a[7:2]];
            e     = ram_m[a[7:2]];
        end else if (in_mmio(a)) begin
            case (a[3:2])
                2'd0:    e = gpio_m;
                2'd1:    e = cycle_m;
                2'd3:    e = {16'h0, 8'(n), 5'b0, ovf_m, (n == 0), (n == DEPTH)};
                default: e = 32'h0;
            endcase
        end
    endtask

    // Advance the model across one rising edge using the present inputs.
    task automatic model_edge();
        bit pop;
        pop = (q.size() != 0) && dbg_ready;
        if (MemWrite && ALUResult < 32'h100) begin
            ram_m[ALUResult[7:2]]     = WriteData;
            ram_known[ALUResult[7:2]] = 1'b1;
        end
        if (reset) begin
            gpio_m  = 32'h0;
            cycle_m = 32'h0;
            ovf_m   = 1'b0;
            q.delete();
        end else begin
            cycle_m = cycle_m + 32'd1;
            if (pop) void'(q.pop_front());
            if (MemWrite && in_mmio(ALUResult)) begin
                case (ALUResult[3:2])
                    2'd0: gpio_m = WriteData;
                    2'd2: if (q.size() < DEPTH) q.push_back(WriteData[7:0]);
                          else ovf_m = 1'b1;
                    2'd3: if (WriteData[2]) ovf_m = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e;
        bit k;
        chk("gpio_out", gpio_out, gpio_m);
        chk("dbg_valid", 32'(dbg_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("dbg_data", 32'(dbg_data), 32'(q[0]));
        model_rd(ALUResult, e, k);
        if (k) chk("ReadData", ReadData, e);
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        MemWrite  = we;
        ALUResult = a;
        WriteData = wd;
        dbg_ready = rdy;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] fill [4];
        int bias;
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        for (int i = 0; i < 64; i++) ram_known[i] = 1'b0;

        reset = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0; dbg_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;

        // Reset state
        drive(1'b0, A_ST, 32'h0, 1'b0);
        chk("rst_status", ReadData, 32'h0000_0002);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_valid", 32'(dbg_valid), 32'h0);
        drive(1'b0, A_CYC, 32'h0, 1'b0);
        chk("rst_cycle", ReadData, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(1'b0, A_CYC, 32'h0, 1'b0);
        end
        chk("cycle_5", ReadData, 32'd5);

        // RAM write/read, ignored byte offset, unmapped read
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        tick();
        drive(1'b0, 32'h10, 32'h0, 1'b0);
        chk("ram_rd", ReadData, 32'hDEAD_BEEF);
        drive(1'b0, 32'h13, 32'h0, 1'b0);
        chk("ram_rd_off", ReadData, 32'hDEAD_BEEF);
        drive(1'b0, 32'h400, 32'h0, 1'b0);
        chk("unmapped", ReadData, 32'h0);
        // Same-cycle write then read returns the old word
        drive(1'b1, 32'h10, 32'h1234_5678, 1'b0);
        chk("ram_old", ReadData, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        chk("ram_new", ReadData, 32'h1234_5678);
        tick();

        // GPIO
        drive(1'b1, A_GPIO, 32'hA5A5_0001, 1'b0);
        tick();
        drive(1'b0, A_GPIO, 32'h0, 1'b0);
        chk("gpio_wr", gpio_out, 32'hA5A5_0001);

        // FIFO fill, overflow, clear
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, A_TX, {24'h0, fill[i]}, 1'b0);
            chk("tx_read0", ReadData, 32'h0);
            tick();
        end
        drive(1'b0, A_ST, 32'h0, 1'b0);
        chk("st_full", ReadData, 32'h0000_0401);
        drive(1'b1, A_TX, 32'h55, 1'b0);
        tick();
        drive(1'b0, A_ST, 32'h0, 1'b0);
        chk("st_ovf", ReadData, 32'h0000_0405);
        drive(1'b1, A_ST, 32'h4, 1'b0);
        tick();
        drive(1'b0, A_ST, 32'h0, 1'b0);
        chk("st_clr", ReadData, 32'h0000_0401);

        // Drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, A_ST, 32'h0, 1'b1);
            chk("drain_valid", 32'(dbg_valid), 32'h1);
            chk("drain_data", 32'(dbg_data), 32'(fill[i]));
            tick();
        end
        drive(1'b0, A_ST, 32'h0, 1'b1);
        chk("drain_empty", 32'(dbg_valid), 32'h0);
        chk("drain_status", ReadData, 32'h0000_0002);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, A_TX, 32'hA1 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, A_TX, 32'h66, 1'b1);
        tick();
        drive(1'b0, A_ST, 32'h0, 1'b0);
        chk("simul_status", ReadData, 32'h0000_0401);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, A_ST, 32'h0, 1'b1);
            tick();
        end
        drive(1'b0, A_ST, 32'h0, 1'b1);
        chk("simul_last_gone", ReadData, 32'h0000_0002);

        // Reset mid-drain
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, A_TX, 32'h70 + 32'(i), 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(1'b0, A_ST, 32'h0, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, A_ST, 32'h0, 1'b0);
        chk("mid_rst_status", ReadData, 32'h0000_0002);
        chk("mid_rst_valid", 32'(dbg_valid), 32'h0);
        chk("mid_rst_gpio", gpio_out, 32'h0);
        drive(1'b0, 32'h10, 32'h0, 1'b0);
        chk("mid_rst_ram", ReadData, 32'hDEAD_BEEF);
        tick();

        // Randomized traffic against the model
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            logic        we;
            if (c % 200 == 0) bias = int'($urandom_range(5, 95));
            reset = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 6))
                0, 1:    a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                2:       a = A_GPIO + 32'($urandom_range(0, 3));
                3:       a = A_CYC + 32'($urandom_range(0, 3));
                4:       a = A_TX + 32'($urandom_range(0, 3));
                5:       a = A_ST + 32'($urandom_range(0, 3));
                default: a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(32'h100, 32'hFFF))
                                                         : 32'h1010 + 32'($urandom_range(0, 255));
            endcase
            we = ($urandom_range(0, 1) != 0) && !reset;
            drive(we, a, $urandom, ($urandom_range(0, 99) < bias));
            tick();
        end
        reset = 1'b0;
        drive(1'b0, A_ST, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
